// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master.
// State encoding, bus widths and the slave-select bit position.
package apb_ctrl_pkg;

  localparam int TIMEOUT_DEF = 15;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int REQ_AW      = ADDR_W + 1;
  localparam int SEL_BIT     = ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with an exclude input.
// Ties go to the requester that was not granted last.
module rr_arb2
  import apb_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       excl_en_i,
  input  logic       excl_idx_i,
  input  logic       take_i,
  output logic       gnt_o,
  output logic       idx_o
);

  logic       last_q;
  logic       last_d;
  logic [1:0] eff;

  assign eff   = req_i & ~(excl_en_i ? onehot2(excl_idx_i) : 2'b00);
  assign gnt_o = |eff;

  always_comb begin
    idx_o = 1'b0;
    unique case (eff)
      2'b11:   idx_o = ~last_q;
      2'b10:   idx_o = 1'b1;
      default: idx_o = 1'b0;
    endcase
  end

  assign last_d = (take_i && gnt_o) ? idx_o : last_q;

  // Requester 1 counts as last served so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master shared by two requesters: SETUP/ACCESS sequencing,
// wait-state timeout and back-to-back hand-over between requesters.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_write,
  input  logic              req1_write,
  input  logic [REQ_AW-1:0] req0_addr,
  input  logic [REQ_AW-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_done,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e            state_q, state_d;
  logic              own_q, own_d;
  logic              write_q, write_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt;
  logic              gnt_idx;
  logic              excl_en;
  logic              take;
  logic              load;
  logic              tmo;
  logic              g_write;
  logic [REQ_AW-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  rr_arb2 u_arb (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .req_i      ({req1_valid, req0_valid}),
    .excl_en_i  (excl_en),
    .excl_idx_i (own_q),
    .take_i     (take),
    .gnt_o      (gnt),
    .idx_o      (gnt_idx)
  );

  assign g_write = gnt_idx ? req1_write : req0_write;
  assign g_addr  = gnt_idx ? req1_addr  : req0_addr;
  assign g_wdata = gnt_idx ? req1_wdata : req0_wdata;
  assign tmo     = (cnt_q == TMO);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = 2'b00;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    excl_en = 1'b0;
    take    = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = 1'b1;
        if (gnt) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (PREADY || tmo) begin
          done_d  = onehot2(own_q);
          err_d   = !PREADY;
          if (!PREADY) begin
            rdata_d = '0;
          end else if (!write_q) begin
            rdata_d = sel_q ? PRDATA2 : PRDATA1;
          end
          // The finishing requester still shows valid this edge.
          excl_en = 1'b1;
          take    = 1'b1;
          if (gnt) begin
            state_d = SETUP;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      own_d   = gnt_idx;
      write_d = g_write;
      sel_d   = g_addr[SEL_BIT];
      addr_d  = g_addr[ADDR_W-1:0];
      wdata_d = g_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign PSEL1     = (state_q != IDLE) && !sel_q;
  assign PSEL2     = (state_q != IDLE) && sel_q;
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a transaction-level model
// compared every cycle, plus literal checks on logged completions.
module tb_apb_master_ctrl;

  localparam int TO = 15;

  typedef struct {
    logic       w;
    logic [8:0] a;
    logic [7:0] d;
  } txn_t;

  typedef struct {
    int         owner;
    logic       er;
    logic [7:0] rd;
    logic       p1;
    logic       p2;
    logic       pen;
    int         cyc;
  } ev_t;

  logic       PCLK, PRESETn;
  logic       req0_valid, req1_valid, req0_write, req1_write;
  logic [8:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_done, req1_done, err;
  logic [7:0] rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE, PREADY;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;

  apb_master_ctrl #(.TIMEOUT(TO)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_write (req0_write),
    .req1_write (req1_write),
    .req0_addr  (req0_addr),
    .req1_addr  (req1_addr),
    .req0_wdata (req0_wdata),
    .req1_wdata (req1_wdata),
    .req0_done  (req0_done),
    .req1_done  (req1_done),
    .rdata      (rdata),
    .err        (err),
    .PSEL1      (PSEL1),
    .PSEL2      (PSEL2),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA1    (PRDATA1),
    .PRDATA2    (PRDATA2),
    .PREADY     (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Bus-side slave memories, written only by real APB write accesses.
  logic [7:0] smem1 [256];
  logic [7:0] smem2 [256];
  assign PRDATA1 = smem1[PADDR];
  assign PRDATA2 = smem2[PADDR];
  always @(posedge PCLK) begin
    if (PENABLE && PREADY && PWRITE) begin
      if (PSEL1) smem1[PADDR] <= PWDATA;
      if (PSEL2) smem2[PADDR] <= PWDATA;
    end
  end

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pen_cnt, psel1_cnt, setup_cnt;
  int mode = 0;
  int nwait = 0;

  txn_t q0[$];
  txn_t q1[$];
  ev_t  evq[$];

  // Model: one in-flight transfer described by its age since grant.
  logic [7:0] mmem [512];
  logic       m_busy, m_write;
  logic [8:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [1:0] m_done;
  logic       m_err;
  int         m_owner, m_last, m_age, m_wait;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    m_done  = 2'b00;
    m_err   = 1'b0;
    m_owner = 0;
    m_last  = 1;
    m_age   = 0;
    m_wait  = 0;
  endtask

  task automatic m_pick(input logic [1:0] v);
    int g;
    if (v == 2'b00) return;
    if (v == 2'b11) g = (m_last == 1) ? 0 : 1;
    else g = v[1] ? 1 : 0;
    m_busy  = 1'b1;
    m_age   = 0;
    m_wait  = 0;
    m_owner = g;
    m_last  = g;
    if (g == 0) begin
      m_write = req0_write;
      m_addr  = req0_addr;
      m_wdata = req0_wdata;
    end else begin
      m_write = req1_write;
      m_addr  = req1_addr;
      m_wdata = req1_wdata;
    end
  endtask

  task automatic model_step();
    logic [1:0] v;
    if (!PRESETn) begin
      model_reset();
      return;
    end
    v = {req1_valid, req0_valid};
    m_done = 2'b00;
    m_err  = 1'b0;
    if (m_busy && m_age == 0) begin
      m_age = 1;
      m_wait = 0;
    end else if (m_busy) begin
      if (PREADY || m_wait == TO) begin
        m_done[m_owner] = 1'b1;
        m_err = !PREADY;
        if (!PREADY) m_rdata = 8'h00;
        else if (m_write) mmem[m_addr] = m_wdata;
        else m_rdata = mmem[m_addr];
        m_busy = 1'b0;
        v[m_owner] = 1'b0;
        m_pick(v);
      end else begin
        m_wait++;
        m_age++;
      end
    end else begin
      m_pick(v);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    if (q0.size() != 0) begin
      req0_write = q0[0].w; req0_addr = q0[0].a; req0_wdata = q0[0].d;
    end
    if (q1.size() != 0) begin
      req1_write = q1[0].w; req1_addr = q1[0].a; req1_wdata = q1[0].d;
    end
    if (mode == 0) PREADY = 1'b1;
    else if (mode == 1) PREADY = m_busy && m_age >= 1 && m_wait >= nwait;
    else PREADY = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [30:0] outs();
    return {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
            req0_done, req1_done, rdata, err};
  endfunction

  task automatic tick();
    logic [30:0] act, exp, msk;
    @(negedge PCLK);
    cyc++;
    exp = {m_busy && !m_addr[8], m_busy && m_addr[8],
           m_busy && m_age >= 1, m_write, m_addr[7:0], m_wdata,
           m_done[0], m_done[1], m_rdata, m_err};
    act = outs();
    msk = '1;
    if (!m_busy && PRESETn) msk[27:11] = '0;
    if (m_done == 2'b00) msk[0] = 1'b0;
    compared++;
    if ((act & msk) !== (exp & msk)) begin
      mismatched++;
      $display("FAIL cycle_cmp cyc=%0d got=%08h expected=%08h",
               cyc, act & msk, exp & msk);
    end
    if (req0_done || req1_done)
      evq.push_back('{req1_done ? 1 : 0, err, rdata,
                      PSEL1, PSEL2, PENABLE, cyc});
    pen_cnt   += PENABLE ? 1 : 0;
    psel1_cnt += PSEL1 ? 1 : 0;
    setup_cnt += ((PSEL1 || PSEL2) && !PENABLE) ? 1 : 0;
    if (PRESETn) begin
      if (m_done[0] && q0.size() != 0) q0.delete(0);
      if (m_done[1] && q1.size() != 0) q1.delete(0);
    end
    drive_reqs();
    model_step();
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !m_busy &&
                 m_done == 2'b00) && n < limit);
    compared++;
    if (n >= limit) begin
      mismatched++;
      $display("FAIL run_bound: got %0d cycles, required < %0d", n, limit);
    end
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    drive_reqs();
    tick();
    tick();
    PRESETn = 1'b1;
  endtask

  task automatic mark();
    pen_cnt = 0;
    psel1_cnt = 0;
    setup_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, start, n;
    ev_t e;
    mode = 0;
    mark();
    do_reset();
    chk("reset_outs_low", int'(outs()), 0);
    chk("reset_outs_hi", int'(outs()), 0);

    // Single write, zero wait states.
    mark();
    base = evq.size();
    start = cyc + 1;
    q0.push_back('{1'b1, 9'h005, 8'hA5});
    run_idle(50);
    chk("s1_events", evq.size() - base, 1);
    if (evq.size() > base) begin
      e = evq[base];
      chk("s1_owner", e.owner, 0);
      chk("s1_latency", e.cyc - start, 3);
      chk("s1_err", int'(e.er), 0);
    end
    chk("s1_mem", int'(smem1[5]), 8'hA5);
    chk("s1_pen_cycles", pen_cnt, 1);
    chk("s1_setup_cycles", setup_cnt, 1);

    // Write then read on slave 2.
    mark();
    q0.push_back('{1'b1, 9'h105, 8'h3C});
    run_idle(50);
    base = evq.size();
    q1.push_back('{1'b0, 9'h105, 8'h00});
    run_idle(50);
    chk("s2_psel1_never", psel1_cnt, 0);
    chk("s2_mem2", int'(smem2[5]), 8'h3C);
    chk("s2_events", evq.size() - base, 1);
    if (evq.size() > base) begin
      e = evq[base];
      chk("s2_owner", e.owner, 1);
      chk("s2_rdata", int'(e.rd), 8'h3C);
    end

    // Four wait states; write must leave rdata alone.
    mark();
    mode = 1;
    nwait = 4;
    base = evq.size();
    q1.push_back('{1'b1, 9'h010, 8'h77});
    run_idle(60);
    chk("s4_pen_cycles", pen_cnt, 5);
    chk("s4_events", evq.size() - base, 1);
    if (evq.size() > base) begin
      e = evq[base];
      chk("s4_err", int'(e.er), 0);
      chk("s4_rdata_kept", int'(e.rd), 8'h3C);
    end

    // Timeout on both requesters; req0 wins the tie.
    mark();
    mode = 2;
    base = evq.size();
    q0.push_back('{1'b0, 9'h020, 8'h00});
    q1.push_back('{1'b1, 9'h121, 8'h99});
    run_idle(200);
    chk("s5_pen_cycles", pen_cnt, 2 * (TO + 1));
    chk("s5_events", evq.size() - base, 2);
    if (evq.size() > base + 1) begin
      e = evq[base];
      chk("s5_first_owner", e.owner, 0);
      chk("s5_first_err", int'(e.er), 1);
      chk("s5_first_rdata", int'(e.rd), 0);
      chk("s5_psel1_dropped", int'(e.p1), 0);
      chk("s5_next_setup", int'({e.p2, e.pen}), 2);
      e = evq[base + 1];
      chk("s5_second_owner", e.owner, 1);
      chk("s5_second_err", int'(e.er), 1);
    end

    // Ready arrives exactly when the wait count hits the limit.
    mark();
    mode = 1;
    nwait = TO;
    base = evq.size();
    q0.push_back('{1'b0, 9'h005, 8'h00});
    run_idle(60);
    chk("s6_pen_cycles", pen_cnt, TO + 1);
    chk("s6_events", evq.size() - base, 1);
    if (evq.size() > base) begin
      e = evq[base];
      chk("s6_err", int'(e.er), 0);
      chk("s6_rdata", int'(e.rd), 8'hA5);
    end

    // Contention straight out of reset.
    mode = 0;
    do_reset();
    mark();
    base = evq.size();
    q0.push_back('{1'b1, 9'h030, 8'h11});
    q0.push_back('{1'b1, 9'h031, 8'h22});
    q1.push_back('{1'b1, 9'h130, 8'h33});
    q1.push_back('{1'b1, 9'h131, 8'h44});
    run_idle(60);
    chk("s3_events", evq.size() - base, 4);
    if (evq.size() > base + 3) begin
      chk("s3_order", evq[base].owner * 8 + evq[base + 1].owner * 4 +
                      evq[base + 2].owner * 2 + evq[base + 3].owner, 5);
      chk("s3_span", evq[base + 3].cyc - evq[base].cyc, 6);
    end
    chk("s3_setup_cycles", setup_cnt, 4);
    chk("s3_mem", int'({smem1[8'h31], smem2[8'h31]}), 16'h2244);

    // Reset during ACCESS: no done, no retry, req0 wins afterwards.
    mode = 2;
    q0.push_back('{1'b1, 9'h040, 8'h5A});
    n = 0;
    while (!(m_busy && m_age >= 1) && n < 20) begin
      tick();
      n++;
    end
    @(posedge PCLK);
    #2;
    chk("s7_in_access", int'(PENABLE), 1);
    base = evq.size();
    PRESETn = 1'b0;
    #1;
    chk("s7_async_outs", int'(outs()), 0);
    q0.delete();
    q1.delete();
    mode = 0;
    model_reset();
    drive_reqs();
    tick();
    tick();
    PRESETn = 1'b1;
    chk("s7_no_done", evq.size() - base, 0);
    q1.push_back('{1'b1, 9'h150, 8'hC3});
    q0.push_back('{1'b1, 9'h050, 8'h3C});
    run_idle(60);
    chk("s7_events", evq.size() - base, 2);
    if (evq.size() > base) chk("s7_first_tie", evq[base].owner, 0);
    chk("s7_not_retried", int'(smem1[8'h40]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max ACCESS cycles without PREADY before abort.
REQ-002 PCLK  in  1  APB clock; all state updates on rising edge.
REQ-003 PRESETn  in  1  reset; asynchronous, active-low.
REQ-004 req0_valid / req1_valid  in  1  requester N has a pending transfer.
REQ-005 req0_write / req1_write  in  1  1 = write, 0 = read.
REQ-006 req0_addr / req1_addr  in  9  bit 8 = slave select (0 = slave 1, 1 = slave 2), bits 7:0 = PADDR.
REQ-007 req0_wdata / req1_wdata  in  8  write data.
REQ-008 req0_done / req1_done  out  1  one-cycle completion pulse to the owning requester.
REQ-009 rdata  out  8  read data; valid while a done pulse is high.
REQ-010 err  out  1  timeout flag; valid while a done pulse is high.
REQ-011 PSEL1, PSEL2  out  1  slave selects; at most one high.
REQ-012 PENABLE, PWRITE  out  1  APB access phase and direction.
REQ-013 PADDR, PWDATA  out  8  APB address and write data.
REQ-014 PRDATA1, PRDATA2  in  8  slave read data.
REQ-015 PREADY  in  1  combined slave ready.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS.
REQ-017 IDLE with any valid: grant one requester, latch write/addr/wdata, go to SETUP next edge; no valid: stay in IDLE.
REQ-018 SETUP: selected PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from latched request; exactly 1 cycle, then ACCESS.
REQ-019 ACCESS: PSELx=1, PENABLE=1, all APB outputs held stable until exit.
REQ-020 ACCESS with PREADY=1 at an edge: transfer completes; on a read, rdata captures PRDATA1 or PRDATA2 per the latched select; err=0; owner done pulses next cycle.
REQ-021 Completion arbitration excludes the completing requester; other requester valid -> SETUP directly (back-to-back, PSEL stays high, PENABLE drops); else IDLE.
REQ-022 Arbitration: only one valid -> grant it; both valid -> grant the requester not served last (round-robin).
REQ-023 Wait counter: cleared on ACCESS entry, +1 per ACCESS cycle with PREADY=0.
REQ-024 Counter reaching TIMEOUT with PREADY=0 -> abort: PSEL/PENABLE drop next cycle, done pulses with err=1 and rdata=8'h00; next state follows REQ-021.
REQ-025 PREADY=1 in the same cycle the counter reaches TIMEOUT -> normal completion, err=0.
REQ-026 Write completion leaves rdata unchanged.
REQ-027 req inputs are ignored outside the grant edge; a requester drops valid on seeing done.
REQ-028 Minimum latency: valid in IDLE -> done pulse 3 cycles later with PREADY=1 on the first ACCESS cycle.

Reset
REQ-029 PRESETn=0 asynchronously forces: state IDLE; PSEL1, PSEL2, PENABLE, PWRITE, done, err = 0; PADDR, PWDATA, rdata = 8'h00; counter 0; last-served = requester 1, so requester 0 wins the first tie.
REQ-030 Reset mid-transfer aborts with no done pulse; the transfer is not retried.

Structure
REQ-031 Shared package apb_ctrl_pkg holds: state encoding, TIMEOUT default, address/data widths, slave-select bit index.
REQ-032 Sub-module rr_arb2 (two-input round-robin, exclude input, last-served register); FSM, counter and datapath stay in apb_master_ctrl.

Verification
REQ-033 Write: req0 write addr 9'h005 data 8'hA5, PREADY=1 immediately -> PSEL1 SETUP 1 cycle, ACCESS 1 cycle, req0_done, err=0, slave 1 mem[5]=A5.
REQ-034 Read: req1 read addr 9'h105 after a write of 8'h3C there -> PSEL2 only, rdata=8'h3C with req1_done.
REQ-035 Contention: both valid from reset, PREADY=1 always -> grants 0,1,0,1, back-to-back with no IDLE between, PENABLE low 1 cycle each.
REQ-036 Wait states: PREADY held low for 4 ACCESS cycles -> APB outputs stable throughout, done on cycle 5, err=0.
REQ-037 Timeout: PREADY never high, TIMEOUT=15 -> done with err=1, rdata=8'h00, PSEL low next cycle; the other pending requester is served next.
REQ-038 Reset: PRESETn low during ACCESS -> all outputs zero immediately, no done; after release, first tie goes to requester 0.
